// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised next-PC select
// (trap > redirect > stall > return/call prediction > sequential) and a circular return-address stack.
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              IALIGN       = 32,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           stall,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   input  logic                           trap_valid,
   input  logic [XLEN-1:0]                trap_vector,
   input  logic                           call_push,
   input  logic [XLEN-1:0]                call_target,
   input  logic                           ret_pop,
   output logic [XLEN-1:0]                pc,
   output logic                           misalign_err,
   output logic                           ras_underflow,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

   localparam int              MASK_BITS = $clog2(IALIGN / 8);
   localparam int              PTR_W     = $clog2(RAS_DEPTH);
   localparam int              CNT_W     = $clog2(RAS_DEPTH + 1);
   localparam logic [XLEN-1:0] LOW_MASK  = XLEN'((1 << MASK_BITS) - 1);
   localparam logic [XLEN-1:0] STEP      = XLEN'(4);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             misalign_q, misalign_d;
   logic             underflow_q, underflow_d;

   logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [XLEN-1:0]  wr_data;

   logic [XLEN-1:0]  pc_inc;
   logic [PTR_W-1:0] top_ptr;
   logic [XLEN-1:0]  top_data;
   logic             ras_empty;

   // ptr_q addresses the next free slot; the top of stack sits one below it (mod depth).
   assign pc_inc    = pc_q + STEP;
   assign top_ptr   = ptr_q - PTR_W'(1);
   assign top_data  = ras_mem[top_ptr];
   assign ras_empty = (cnt_q == '0);

   always_comb begin
      pc_d        = pc_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      misalign_d  = 1'b0;
      underflow_d = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = ptr_q;
      wr_data     = pc_inc;

      if (trap_valid) begin
         pc_d  = trap_vector & ~LOW_MASK;
         cnt_d = '0;
         ptr_d = '0;
      end else if (redirect_valid) begin
         pc_d       = redirect_pc & ~LOW_MASK;
         misalign_d = |(redirect_pc & LOW_MASK);
      end else if (stall) begin
         pc_d = pc_q;
      end else if (ret_pop && call_push && !ras_empty) begin
         // Return then call in the same fetch: swap the top entry in place.
         pc_d    = top_data;
         wr_en   = 1'b1;
         wr_addr = top_ptr;
      end else if (ret_pop && !call_push) begin
         if (!ras_empty) begin
            pc_d  = top_data;
            ptr_d = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            pc_d        = pc_inc;
            underflow_d = 1'b1;
         end
      end else if (call_push) begin
         // Also covers push+pop on an empty stack, which flags the missed return.
         wr_en       = 1'b1;
         wr_addr     = ptr_q;
         ptr_d       = ptr_q + PTR_W'(1);
         pc_d        = call_target & ~LOW_MASK;
         underflow_d = ret_pop;
         if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q        <= RESET_VECTOR;
         ptr_q       <= '0;
         cnt_q       <= '0;
         misalign_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         misalign_q  <= misalign_d;
         underflow_q <= underflow_d;
      end
   end

   // Stack storage carries no reset; validity is tracked solely by cnt_q.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         ras_mem[wr_addr] <= wr_data;
      end
   end

   assign pc            = pc_q;
   assign misalign_err  = misalign_q;
   assign ras_underflow = underflow_q;
   assign ras_count     = cnt_q;

endmodule
